// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: owns the PC, keeps one instruction-memory read in flight,
// buffers the returned word for decode, and handles redirects and fetch faults.
module ysyx_23060240_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] inst_cnt
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            redir_mis;

  assign redir_mis      = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign fetch_fault    = (state == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
      inst_cnt <= '0;
    end else if (state != S_FAULT && redir_mis) begin
      state <= S_FAULT;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect_valid) pc <= redirect_pc;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // the old-PC request is already in flight; its response must be thrown away
            if (imem_req_ready) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else if (imem_rsp_err) begin
              state <= S_FAULT;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // a redirect kills the buffered word even if decode is taking it
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc       <= pc + 32'd4;
            inst_cnt <= inst_cnt + 32'd1;
            state    <= S_REQ;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Randomized lockstep bench for the fetch unit against a transaction-level model
// (flags for booting / outstanding / buffered / dropping / faulted) and a memory stub.
module tb_ysyx_23060240_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;
  logic [31:0] inst_cnt;

  always #5 clk = ~clk;

  ysyx_23060240_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .inst_cnt(inst_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
  bit m_boot, m_out, m_have, m_drop, m_flt;
  // memory stub
  bit pend;
  int dly;

  function automatic bit m_reqv();
    return !m_flt && !m_boot && !m_out && !m_have;
  endfunction

  function automatic bit pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_inst = '0; m_inst_pc = '0; m_cnt = '0;
    m_boot = 1; m_out = 0; m_have = 0; m_drop = 0; m_flt = 0;
    pend = 0; dly = 0;
  endtask

  task automatic model_step();
    if (m_flt) begin
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        m_flt = 1; m_have = 0;
      end else begin
        if (m_have) m_have = 0;
        else if (m_out) begin
          if (imem_rsp_valid) begin m_out = 0; m_drop = 0; end
          else m_drop = 1;
        end else if (!m_boot && imem_req_ready) begin
          m_out = 1; m_drop = 1;
        end
        m_boot = 0;
        m_pc = redirect_pc;
      end
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_have) begin
      if (inst_ready) begin m_have = 0; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; end
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (imem_rsp_err) m_flt = 1;
        else begin m_have = 1; m_inst = imem_rsp_data; m_inst_pc = m_pc; end
      end
    end else if (imem_req_ready) begin
      m_out = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_err = 0;
    inst_ready = 0; redirect_valid = 0;
    #2;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // phase knobs: cycles, ready%, inst_ready%, redirect%, misaligned%, err%, max delay, reset%
  int ph_len [4] = '{15, 200, 400, 600};
  int ph_rdy [4] = '{100, 60, 70, 70};
  int ph_ir  [4] = '{100, 25, 60, 60};
  int ph_rd  [4] = '{0, 0, 15, 10};
  int ph_mis [4] = '{0, 0, 0, 4};
  int ph_err [4] = '{0, 0, 0, 6};
  int ph_dly [4] = '{0, 2, 2, 3};
  int ph_rst [4] = '{0, 0, 0, 1};

  initial begin
    int fcyc;
    bit acc;
    fcyc = 0;
    @(negedge clk);
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        if (c != 0 || p != 0) begin
          @(negedge clk);
          chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_reqv()});
          chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
          chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_flt});
          chk("inst_cnt", inst_cnt, m_cnt);
          if (m_reqv()) chk("req_addr", imem_req_addr, m_pc);
          if (m_have) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
          end
          fcyc = m_flt ? fcyc + 1 : 0;
          if (fcyc >= 20 || pct(ph_rst[p])) begin
            fcyc = 0;
            do_reset();
          end
        end
        // memory response
        imem_rsp_valid = 0;
        imem_rsp_err = 0;
        imem_rsp_data = (p == 0) ? 32'h0000_0013 : $urandom;
        if (pend) begin
          if (dly == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_err = pct(ph_err[p]);
            pend = 0;
          end else dly--;
        end
        imem_req_ready = pct(ph_rdy[p]);
        inst_ready = pct(ph_ir[p]);
        redirect_valid = pct(ph_rd[p]);
        redirect_pc = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
        if (pct(ph_mis[p])) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        acc = m_reqv() && imem_req_ready;
        model_step();
        if (acc) begin
          pend = 1;
          dly = $urandom_range(0, ph_dly[p]);
        end
      end
    end
    @(negedge clk);
    chk("final_cnt", inst_cnt, m_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
